// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] AN_ALL_OFF = 4'b1111;

   // Scan index: which digit slot is currently driven.
   typedef enum logic [1:0] {
      IDX_0 = 2'd0,
      IDX_1 = 2'd1,
      IDX_2 = 2'd2,
      IDX_3 = 2'd3
   } idx_t;

   // Frame snapshot: everything the display decisions depend on.
   typedef struct packed {
      logic [3:0] d3;
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
      logic       blank_lead;
      logic [3:0] dp_mask;
   } snap_t;

   // Active-low one-hot anode pattern for a scan index.
   function automatic logic [3:0] an_onehot_n(input idx_t idx);
      logic [3:0] onehot;
      onehot = 4'b0001 << idx;
      return ~onehot;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low 7-segment pattern; codes 10..15 show a dash.
module bcd_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pure lookup; anything outside 0..9 is flagged visually with a dash.
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_display_mux.sv
// Four-digit multiplexed 7-segment driver with ghost-blanking gap,
// leading-zero suppression and per-frame input snapshot.
//
// Scan index states:
//   state | meaning
//   IDX_0 | driving digit 0 (rightmost)
//   IDX_1 | driving digit 1
//   IDX_2 | driving digit 2
//   IDX_3 | driving digit 3 (leftmost); its slot tick captures the next snapshot
module seg_display_mux
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int GHOST_CYCLES = 16
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic       blank_lead,
   input  logic [3:0] dp_mask,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int               CNT_W     = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GHOST_LIM = CNT_W'(GHOST_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   idx_t             idx_q, idx_d;
   snap_t            snap_q, snap_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             slot_tick;
   logic             ghost;
   logic             blank3, blank2, blank1;
   logic [3:0]       digit_sel;
   logic             digit_blank;
   logic             digit_dp;
   logic [6:0]       dec_seg;

   // State and output registers; reset clears the snapshot so the first frame reads "0000".
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         idx_q  <= IDX_0;
         snap_q <= '0;
         an_q   <= AN_ALL_OFF;
         seg_q  <= SEG_BLANK;
         dp_q   <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end

   // Refresh counter, scan index advance and end-of-frame snapshot capture.
   always_comb begin
      slot_tick = (cnt_q == CNT_LAST);
      cnt_d     = slot_tick ? '0 : cnt_q + CNT_W'(1);
      idx_d     = idx_q;
      snap_d    = snap_q;
      if (slot_tick) begin
         case (idx_q)
            IDX_0:   idx_d = IDX_1;
            IDX_1:   idx_d = IDX_2;
            IDX_2:   idx_d = IDX_3;
            IDX_3:   idx_d = IDX_0;
            default: idx_d = IDX_0;
         endcase
         if (idx_q == IDX_3) begin
            snap_d.d3         = d3;
            snap_d.d2         = d2;
            snap_d.d1         = d1;
            snap_d.d0         = d0;
            snap_d.blank_lead = blank_lead;
            snap_d.dp_mask    = dp_mask;
         end
      end
   end

   // Leading-zero chain: a digit may only blank if every digit to its left is blanked.
   always_comb begin
      blank3 = snap_q.blank_lead && (snap_q.d3 == 4'd0);
      blank2 = blank3 && (snap_q.d2 == 4'd0);
      blank1 = blank2 && (snap_q.d1 == 4'd0);
   end

   // Select the active digit from the snapshot.
   always_comb begin
      digit_sel   = snap_q.d0;
      digit_blank = 1'b0;
      digit_dp    = snap_q.dp_mask[0];
      case (idx_q)
         IDX_0: begin
            digit_sel   = snap_q.d0;
            digit_blank = 1'b0;
            digit_dp    = snap_q.dp_mask[0];
         end
         IDX_1: begin
            digit_sel   = snap_q.d1;
            digit_blank = blank1;
            digit_dp    = snap_q.dp_mask[1];
         end
         IDX_2: begin
            digit_sel   = snap_q.d2;
            digit_blank = blank2;
            digit_dp    = snap_q.dp_mask[2];
         end
         IDX_3: begin
            digit_sel   = snap_q.d3;
            digit_blank = blank3;
            digit_dp    = snap_q.dp_mask[3];
         end
         default: begin
            digit_sel   = snap_q.d0;
            digit_blank = 1'b0;
            digit_dp    = snap_q.dp_mask[0];
         end
      endcase
   end

   bcd_to_seg u_bcd_to_seg (
      .bcd (digit_sel),
      .seg (dec_seg)
   );

   // Next output values; cathodes are also dark during the ghost gap so
   // nothing leaks onto the incoming digit while the anodes switch.
   always_comb begin
      ghost = (cnt_q < GHOST_LIM);
      an_d  = ghost ? AN_ALL_OFF : an_onehot_n(idx_q);
      seg_d = (ghost || digit_blank) ? SEG_BLANK : dec_seg;
      dp_d  = ~(digit_dp & ~digit_blank & ~ghost);
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with REFRESH_DIV=4, GHOST_CYCLES=1.
module tb_seg_display_mux;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] d0, d1, d2, d3;
   logic       blank_lead;
   logic [3:0] dp_mask;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg_display_mux #(
      .REFRESH_DIV  (4),
      .GHOST_CYCLES (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .d0         (d0),
      .d1         (d1),
      .d2         (d2),
      .d3         (d3),
      .blank_lead (blank_lead),
      .dp_mask    (dp_mask),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1,
                         input logic [3:0] a0, input logic bl, input logic [3:0] m);
      d3 = a3; d2 = a2; d1 = a1; d0 = a0; blank_lead = bl; dp_mask = m;
   endtask

   // Advance to the first negedge where digit i freshly becomes active.
   task automatic next_digit(input int i);
      logic [3:0] one;
      logic [3:0] tgt;
      int n;
      one = 4'b0001 << i;
      tgt = ~one;
      n = 0;
      while (an == tgt && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (an != tgt && n < 20) begin @(negedge clk); n++; end
      if (an != tgt) check($sformatf("wait_an%0d", i), 7'(an), 7'(tgt));
   endtask

   task automatic show(input string tag, input int i, input logic [6:0] es, input logic edp);
      next_digit(i);
      check({tag, "_seg"}, seg, es);
      check({tag, "_dp"}, 7'(dp), 7'(edp));
   endtask

   // Guarantee the live inputs are in the snapshot of the frame that follows.
   task automatic load_frame();
      next_digit(0);
      next_digit(3);
      next_digit(0);
   endtask

   logic [3:0] an_exp [16] = '{4'b1111, 4'b1110, 4'b1110, 4'b1110,
                               4'b1111, 4'b1101, 4'b1101, 4'b1101,
                               4'b1111, 4'b1011, 4'b1011, 4'b1011,
                               4'b1111, 4'b0111, 4'b0111, 4'b0111};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4'b1111);

      // Reset hold: outputs dark regardless of inputs.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_an", 7'(an), 7'(4'b1111));
         check("rst_seg", seg, SB);
         check("rst_dp", 7'(dp), 7'(1'b1));
      end
      set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0000);
      reset_n = 1'b1;

      // First frame after release: ghost cycle then three active cycles per slot, all "0".
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check($sformatf("scan_an%0d", k), 7'(an), 7'(an_exp[k]));
         check($sformatf("scan_seg%0d", k), seg, (an_exp[k] == 4'b1111) ? SB : S0);
      end

      // Plain digits 1234.
      set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4'b0000);
      load_frame();
      check("p1234_d0_seg", seg, S4);
      show("p1234_d1", 1, S3, 1'b1);
      show("p1234_d2", 2, S2, 1'b1);
      show("p1234_d3", 3, S1, 1'b1);

      // Leading-zero blanking with dp_mask all on: blanked digits keep dp dark.
      set_in(4'd0, 4'd0, 4'd5, 4'd7, 1'b1, 4'b1111);
      load_frame();
      check("lz57_d0_seg", seg, S7);
      check("lz57_d0_dp", 7'(dp), 7'(1'b0));
      show("lz57_d1", 1, S5, 1'b0);
      show("lz57_d2", 2, SB, 1'b1);
      show("lz57_d3", 3, SB, 1'b1);

      // All zero with blanking: only digit 0 lit.
      set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'b0000);
      load_frame();
      check("lz0_d0_seg", seg, S0);
      show("lz0_d1", 1, SB, 1'b1);
      show("lz0_d2", 2, SB, 1'b1);
      show("lz0_d3", 3, SB, 1'b1);

      // Embedded zero is not leading: 0102 -> _102.
      set_in(4'd0, 4'd1, 4'd0, 4'd2, 1'b1, 4'b0000);
      load_frame();
      check("lz102_d0_seg", seg, S2);
      show("lz102_d1", 1, S0, 1'b1);
      show("lz102_d2", 2, S1, 1'b1);
      show("lz102_d3", 3, SB, 1'b1);

      // Invalid BCD dash and a single decimal point on digit 2.
      set_in(4'd9, 4'd8, 4'd12, 4'd6, 1'b0, 4'b0100);
      load_frame();
      check("inv_d0_seg", seg, S6);
      check("inv_d0_dp", 7'(dp), 7'(1'b1));
      show("inv_d1", 1, SD, 1'b1);
      show("inv_d2", 2, S8, 1'b0);
      show("inv_d3", 3, S9, 1'b1);

      // Snapshot holds mid-frame.
      set_in(4'd0, 4'd5, 4'd0, 4'd3, 1'b0, 4'b0000);
      load_frame();
      check("snap_d0_seg", seg, S3);
      d0 = 4'd8;
      @(negedge clk);
      check("snap_d0_hold", seg, S3);
      next_digit(1);
      d2 = 4'd7;
      show("snap_d2_old", 2, S5, 1'b1);
      show("snap_d3", 3, S0, 1'b1);
      show("snap_d0_new", 0, S8, 1'b1);
      show("snap_d2_new", 2, S7, 1'b1);

      // Asynchronous reset during slot 2, then restart on the zero snapshot.
      next_digit(2);
      reset_n = 1'b0;
      #1;
      check("arst_an", 7'(an), 7'(4'b1111));
      check("arst_seg", seg, SB);
      check("arst_dp", 7'(dp), 7'(1'b1));
      @(negedge clk);
      check("arst_hold_an", 7'(an), 7'(4'b1111));
      reset_n = 1'b1;
      @(negedge clk);
      check("rel_ghost_an", 7'(an), 7'(4'b1111));
      check("rel_ghost_seg", seg, SB);
      @(negedge clk);
      check("rel_d0_an", 7'(an), 7'(4'b1110));
      check("rel_d0_seg", seg, S0);
      show("rel_d1", 1, S0, 1'b1);
      show("rel_d3", 3, S0, 1'b1);
      show("rel_live_d0", 0, S8, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
